// File: rtl/hotel_pkg.sv
// Shared constants and types for the hotel booking controller:
// nightly rates, extras costs and the controller FSM state encoding.
package hotel_pkg;

  localparam logic [15:0] RATE_DELUXE = 16'd700;
  localparam logic [15:0] RATE_STD    = 16'd400;
  localparam logic [15:0] COST_AC     = 16'd200;
  localparam logic [15:0] COST_WIFI   = 16'd100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    MULT   = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/hotel_shift_add_mul.sv
// Sequential BILL_W x DAYS_W shift-add multiplier, one multiplier bit per
// cycle, LSB first. The accumulator is BILL_W+DAYS_W bits so the full
// product is always exact internally.
// Optional feature macro: HOTEL_BILL_SAT_EN (saturate result to all ones
// when the product does not fit in BILL_W bits; otherwise wrap).
// done_o is high during the final step; result_o is valid in that cycle.
module hotel_shift_add_mul #(
  parameter int BILL_W = 16,
  parameter int DAYS_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [BILL_W-1:0] mcand_i,
  input  logic [DAYS_W-1:0] mplier_i,
  output logic              done_o,
  output logic [BILL_W-1:0] result_o
);

  localparam int ACC_W = BILL_W + DAYS_W;
  localparam int CNT_W = (DAYS_W > 1) ? $clog2(DAYS_W) : 1;

  logic              busy_q,   busy_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [ACC_W-1:0]  mcand_q,  mcand_d;
  logic [DAYS_W-1:0] mplier_q, mplier_d;
  logic              last_s;

  // Load operands on start, then add-and-shift one bit per cycle.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    last_s   = busy_q && (cnt_q == CNT_W'(DAYS_W - 1));
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = {CNT_W{1'b0}};
      acc_d    = {ACC_W{1'b0}};
      mcand_d  = {{DAYS_W{1'b0}}, mcand_i};
      mplier_d = mplier_i;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = !last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      mcand_q  <= {ACC_W{1'b0}};
      mplier_q <= {DAYS_W{1'b0}};
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Reduce the exact product to BILL_W bits (saturate or wrap).
  always_comb begin
`ifdef HOTEL_BILL_SAT_EN
    if (|acc_d[ACC_W-1:BILL_W]) begin
      result_o = {BILL_W{1'b1}};
    end else begin
      result_o = acc_d[BILL_W-1:0];
    end
`else
    result_o = acc_d[BILL_W-1:0];
`endif
  end

  assign done_o = last_s;

endmodule

// File: rtl/hotel_booking_ctrl.sv
// Request/response room-booking engine: per-room occupancy/owner table,
// lowest-free-room allocation, checkout by customer ID and a multi-cycle
// bill computation (rate x days) in hotel_shift_add_mul.
// Optional feature macro: HOTEL_BILL_SAT_EN (bill saturation, see multiplier).
module hotel_booking_ctrl
  import hotel_pkg::*;
#(
  parameter int NUM_ROOMS  = 7,
  parameter int NUM_DELUXE = 2,
  parameter int ID_W       = 4,
  parameter int DAYS_W     = 3,
  parameter int BILL_W     = 16,
  localparam int RIDX_W    = $clog2(NUM_ROOMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [ID_W-1:0]      req_id,
  input  logic                 req_ac,
  input  logic                 req_wifi,
  input  logic [DAYS_W-1:0]    req_days,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_ok,
  output logic [RIDX_W-1:0]    rsp_room,
  output logic [BILL_W-1:0]    rsp_bill,
  output logic [NUM_ROOMS-1:0] occupied,
  output logic [RIDX_W:0]      free_count
);

  state_e                state_q, state_d;
  logic                  op_q, op_d, ac_q, ac_d, wifi_q, wifi_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DAYS_W-1:0]     days_q, days_d;
  logic [NUM_ROOMS-1:0]  occ_q, occ_d;
  logic [ID_W-1:0]       owner_q [NUM_ROOMS];
  logic [ID_W-1:0]       owner_d [NUM_ROOMS];
  logic [RIDX_W:0]       fc_q, fc_d;
  logic                  ok_q, ok_d;
  logic [RIDX_W-1:0]     room_q, room_d;
  logic [BILL_W-1:0]     bill_q, bill_d;

  logic                  free_found_s, owned_s, book_ok_s;
  logic [RIDX_W-1:0]     free_idx_s, hit_idx_s;
  logic [BILL_W-1:0]     rate_s, mul_result_s;
  logic                  mul_start_s, mul_done_s;
  logic [RIDX_W:0]       occ_cnt_s;

  // Table scan: lowest free room and lowest occupied room owned by id_q.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {RIDX_W{1'b0}};
    owned_s      = 1'b0;
    hit_idx_s    = {RIDX_W{1'b0}};
    for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = RIDX_W'(i);
      end else if (owner_q[i] == id_q) begin
        owned_s   = 1'b1;
        hit_idx_s = RIDX_W'(i);
      end else begin
        owned_s = owned_s;
      end
    end
    book_ok_s = (days_q != {DAYS_W{1'b0}}) && free_found_s && !owned_s;
  end

  // Nightly rate for the room that would be allocated, plus extras.
  always_comb begin
    if (int'(free_idx_s) < NUM_DELUXE) begin
      rate_s = BILL_W'(RATE_DELUXE);
    end else begin
      rate_s = BILL_W'(RATE_STD);
    end
    if (ac_q) begin
      rate_s = rate_s + BILL_W'(COST_AC);
    end else begin
      rate_s = rate_s;
    end
    if (wifi_q) begin
      rate_s = rate_s + BILL_W'(COST_WIFI);
    end else begin
      rate_s = rate_s;
    end
  end

  hotel_shift_add_mul #(
    .BILL_W (BILL_W),
    .DAYS_W (DAYS_W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_s),
    .mcand_i  (rate_s),
    .mplier_i (days_q),
    .done_o   (mul_done_s),
    .result_o (mul_result_s)
  );

  // FSM next state, request capture, table updates and response fields.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    ac_d        = ac_q;
    wifi_d      = wifi_q;
    days_d      = days_q;
    occ_d       = occ_q;
    owner_d     = owner_q;
    ok_d        = ok_q;
    room_d      = room_q;
    bill_d      = bill_q;
    mul_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          id_d    = req_id;
          ac_d    = req_ac;
          wifi_d  = req_wifi;
          days_d  = req_days;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        ok_d   = 1'b0;
        room_d = {RIDX_W{1'b0}};
        bill_d = {BILL_W{1'b0}};
        if (!op_q) begin
          if (book_ok_s) begin
            for (int i = 0; i < NUM_ROOMS; i++) begin
              if (free_idx_s == RIDX_W'(i)) begin
                occ_d[i]   = 1'b1;
                owner_d[i] = id_q;
              end else begin
                occ_d[i] = occ_q[i];
              end
            end
            ok_d        = 1'b1;
            room_d      = free_idx_s;
            mul_start_s = 1'b1;
            state_d     = MULT;
          end else begin
            state_d = RESP;
          end
        end else begin
          if (owned_s) begin
            for (int i = 0; i < NUM_ROOMS; i++) begin
              if (hit_idx_s == RIDX_W'(i)) begin
                occ_d[i] = 1'b0;
              end else begin
                occ_d[i] = occ_q[i];
              end
            end
            ok_d   = 1'b1;
            room_d = hit_idx_s;
          end else begin
            ok_d = 1'b0;
          end
          state_d = RESP;
        end
      end
      MULT: begin
        if (mul_done_s) begin
          bill_d  = mul_result_s;
          state_d = RESP;
        end else begin
          state_d = MULT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-room count derived from the next occupancy bitmap.
  always_comb begin
    occ_cnt_s = {(RIDX_W + 1){1'b0}};
    for (int i = 0; i < NUM_ROOMS; i++) begin
      occ_cnt_s = occ_cnt_s + {{RIDX_W{1'b0}}, occ_d[i]};
    end
    fc_d = (RIDX_W + 1)'(NUM_ROOMS) - occ_cnt_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: captured request, room table, response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 1'b0;
      id_q   <= {ID_W{1'b0}};
      ac_q   <= 1'b0;
      wifi_q <= 1'b0;
      days_q <= {DAYS_W{1'b0}};
      occ_q  <= {NUM_ROOMS{1'b0}};
      for (int i = 0; i < NUM_ROOMS; i++) begin
        owner_q[i] <= {ID_W{1'b0}};
      end
      fc_q   <= (RIDX_W + 1)'(NUM_ROOMS);
      ok_q   <= 1'b0;
      room_q <= {RIDX_W{1'b0}};
      bill_q <= {BILL_W{1'b0}};
    end else begin
      op_q    <= op_d;
      id_q    <= id_d;
      ac_q    <= ac_d;
      wifi_q  <= wifi_d;
      days_q  <= days_d;
      occ_q   <= occ_d;
      owner_q <= owner_d;
      fc_q    <= fc_d;
      ok_q    <= ok_d;
      room_q  <= room_d;
      bill_q  <= bill_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_ok     = ok_q;
  assign rsp_room   = room_q;
  assign rsp_bill   = bill_q;
  assign occupied   = occ_q;
  assign free_count = fc_q;

endmodule

// File: tb/tb_hotel_booking_ctrl.sv
// Directed self-checking bench for hotel_booking_ctrl (4 rooms, 2 deluxe).
// A second instance with BILL_W=12 exercises bill wrap/saturation.
module tb_hotel_booking_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0, req_ac = 1'b0, req_wifi = 1'b0;
  logic [3:0]  req_id = 4'd0;
  logic [2:0]  req_days = 3'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_ok;
  logic [1:0]  rsp_room;
  logic [15:0] rsp_bill;
  logic [3:0]  occupied;
  logic [2:0]  free_count;

  logic        b_valid = 1'b0, b_ac = 1'b0, b_wifi = 1'b0, b_rsp_ready = 1'b0;
  logic [3:0]  b_id = 4'd0;
  logic [2:0]  b_days = 3'd0;
  logic        b_ready, b_rsp_valid, b_ok;
  logic [1:0]  b_room;
  logic [11:0] b_bill;
  logic [3:0]  b_occ;
  logic [2:0]  b_fc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hotel_booking_ctrl #(
    .NUM_ROOMS(4), .NUM_DELUXE(2), .ID_W(4), .DAYS_W(3), .BILL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id(req_id), .req_ac(req_ac), .req_wifi(req_wifi), .req_days(req_days),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_room(rsp_room), .rsp_bill(rsp_bill),
    .occupied(occupied), .free_count(free_count)
  );

  hotel_booking_ctrl #(
    .NUM_ROOMS(4), .NUM_DELUXE(2), .ID_W(4), .DAYS_W(3), .BILL_W(12)
  ) dut12 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_op(1'b0),
    .req_id(b_id), .req_ac(b_ac), .req_wifi(b_wifi), .req_days(b_days),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_ok(b_ok),
    .rsp_room(b_room), .rsp_bill(b_bill),
    .occupied(b_occ), .free_count(b_fc)
  );

  // Drive one request, wait for its response; lat = edges from accept to
  // rsp_valid (-1 on timeout). Optionally consumes the response.
  task automatic do_req(input logic op, input logic [3:0] id, input logic ac,
                        input logic wifi, input logic [2:0] days, input bit consume,
                        output int lat, output logic ok, output logic [1:0] room,
                        output logic [15:0] bill);
    int n;
    req_op = op; req_id = id; req_ac = ac; req_wifi = wifi; req_days = days;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    lat  = rsp_valid ? n : -1;
    ok   = rsp_ok;
    room = rsp_room;
    bill = rsp_bill;
    if (consume && rsp_valid) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_ok !== 1'b0 ||
        rsp_room !== 2'd0 || rsp_bill !== 16'd0 || occupied !== 4'b0000 ||
        free_count !== 3'd4) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b ok=%b room=%0d bill=%0d occ=%b fc=%0d (want 1 0 0 0 0 0000 4)",
               req_ready, rsp_valid, rsp_ok, rsp_room, rsp_bill, occupied, free_count);
    end
  endtask

  task automatic test_book_first();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    do_req(1'b0, 4'd3, 1'b1, 1'b1, 3'd5, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 4 || ok !== 1'b1 || room !== 2'd0 || bill !== 16'd5000) begin
      failures++;
      $display("FAIL book_first: lat=%0d ok=%b room=%0d bill=%0d (want 4 1 0 5000)", lat, ok, room, bill);
    end
    checks++;
    if (occupied !== 4'b0001 || free_count !== 3'd3) begin
      failures++;
      $display("FAIL book_first_table: occ=%b fc=%0d (want 0001 3)", occupied, free_count);
    end
  endtask

  task automatic test_fill();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    logic [15:0] exp_bill [3];
    exp_bill[0] = 16'd1400; exp_bill[1] = 16'd800; exp_bill[2] = 16'd800;
    for (int k = 0; k < 3; k++) begin
      do_req(1'b0, 4'(4 + k), 1'b0, 1'b0, 3'd2, 1'b1, lat, ok, room, bill);
      checks++;
      if (lat !== 4 || ok !== 1'b1 || room !== 2'(k + 1) || bill !== exp_bill[k]) begin
        failures++;
        $display("FAIL fill_%0d: lat=%0d ok=%b room=%0d bill=%0d (want 4 1 %0d %0d)",
                 k, lat, ok, room, bill, k + 1, exp_bill[k]);
      end
    end
    do_req(1'b0, 4'd7, 1'b0, 1'b0, 3'd2, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || room !== 2'd0 || bill !== 16'd0 ||
        free_count !== 3'd0 || occupied !== 4'b1111) begin
      failures++;
      $display("FAIL full_reject: lat=%0d ok=%b room=%0d bill=%0d fc=%0d occ=%b (want 1 0 0 0 0 1111)",
               lat, ok, room, bill, free_count, occupied);
    end
  endtask

  task automatic test_dup_reject();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    do_req(1'b0, 4'd4, 1'b1, 1'b0, 3'd3, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || room !== 2'd0 || bill !== 16'd0 ||
        occupied !== 4'b1111 || free_count !== 3'd0) begin
      failures++;
      $display("FAIL dup_reject: lat=%0d ok=%b room=%0d bill=%0d occ=%b fc=%0d (want 1 0 0 0 1111 0)",
               lat, ok, room, bill, occupied, free_count);
    end
  endtask

  task automatic test_checkout();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    do_req(1'b1, 4'd3, 1'b0, 1'b0, 3'd0, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b1 || room !== 2'd0 || bill !== 16'd0 ||
        free_count !== 3'd1 || occupied !== 4'b1110) begin
      failures++;
      $display("FAIL checkout_hit: lat=%0d ok=%b room=%0d bill=%0d fc=%0d occ=%b (want 1 1 0 0 1 1110)",
               lat, ok, room, bill, free_count, occupied);
    end
    // zero-day stay rejected even with a free room
    do_req(1'b0, 4'd11, 1'b0, 1'b0, 3'd0, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || room !== 2'd0 || bill !== 16'd0 || free_count !== 3'd1) begin
      failures++;
      $display("FAIL days0_reject: lat=%0d ok=%b room=%0d bill=%0d fc=%0d (want 1 0 0 0 1)",
               lat, ok, room, bill, free_count);
    end
    do_req(1'b0, 4'd8, 1'b0, 1'b1, 3'd3, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 4 || ok !== 1'b1 || room !== 2'd0 || bill !== 16'd2400 || occupied !== 4'b1111) begin
      failures++;
      $display("FAIL rebook_room0: lat=%0d ok=%b room=%0d bill=%0d occ=%b (want 4 1 0 2400 1111)",
               lat, ok, room, bill, occupied);
    end
    do_req(1'b1, 4'd9, 1'b0, 1'b0, 3'd0, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || room !== 2'd0 || occupied !== 4'b1111) begin
      failures++;
      $display("FAIL checkout_miss: lat=%0d ok=%b room=%0d occ=%b (want 1 0 0 1111)", lat, ok, room, occupied);
    end
    do_req(1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 1 || ok !== 1'b1 || room !== 2'd2 || occupied !== 4'b1011 || free_count !== 3'd1) begin
      failures++;
      $display("FAIL checkout_mid: lat=%0d ok=%b room=%0d occ=%b fc=%0d (want 1 1 2 1011 1)",
               lat, ok, room, occupied, free_count);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    int bad;
    do_req(1'b0, 4'd12, 1'b1, 1'b0, 3'd7, 1'b0, lat, ok, room, bill);
    checks++;
    if (lat !== 4 || ok !== 1'b1 || room !== 2'd2 || bill !== 16'd4200) begin
      failures++;
      $display("FAIL bp_first: lat=%0d ok=%b room=%0d bill=%0d (want 4 1 2 4200)", lat, ok, room, bill);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_op = c[0]; req_id = 4'(c); req_days = 3'(c);
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_ok !== 1'b1 ||
          rsp_room !== 2'd2 || rsp_bill !== 16'd4200) bad++;
    end
    req_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: unstable cycles=%0d (want 0)", bad);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || occupied !== 4'b1111) begin
      failures++;
      $display("FAIL bp_release: rdy=%b vld=%b occ=%b (want 1 0 1111)", req_ready, rsp_valid, occupied);
    end
  endtask

  task automatic test_bill_width();
    int n;
    logic [11:0] exp;
`ifdef HOTEL_BILL_SAT_EN
    exp = 12'd4095;
`else
    exp = 12'd2904;
`endif
    b_id = 4'd1; b_ac = 1'b1; b_wifi = 1'b1; b_days = 3'd7; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 4 || b_ok !== 1'b1 || b_room !== 2'd0 || b_bill !== exp) begin
      failures++;
      $display("FAIL bill_w12: lat=%0d ok=%b room=%0d bill=%0d (want 4 1 0 %0d)", n, b_ok, b_room, b_bill, exp);
    end
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic ok; logic [1:0] room; logic [15:0] bill;
    int bad;
    do_req(1'b1, 4'd6, 1'b0, 1'b0, 3'd0, 1'b1, lat, ok, room, bill);
    checks++;
    if (ok !== 1'b1 || room !== 2'd3) begin
      failures++;
      $display("FAIL pre_reset_checkout: ok=%b room=%0d (want 1 3)", ok, room);
    end
    req_op = 1'b0; req_id = 4'd14; req_ac = 1'b0; req_wifi = 1'b1; req_days = 3'd4;
    req_valid = 1'b1;
    @(posedge clk); #1;          // accepted, SEARCH
    req_valid = 1'b0;
    @(posedge clk); #1;          // MULT, room 3 committed
    checks++;
    if (occupied !== 4'b1111) begin
      failures++;
      $display("FAIL mult_commit: occ=%b (want 1111)", occupied);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (occupied !== 4'b0000 || free_count !== 3'd4 || rsp_valid !== 1'b0 ||
        rsp_ok !== 1'b0 || rsp_bill !== 16'd0 || b_occ !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: occ=%b fc=%0d vld=%b ok=%b bill=%0d occ12=%b (want 0000 4 0 0 0 0000)",
               occupied, free_count, rsp_valid, rsp_ok, rsp_bill, b_occ);
    end
    #13 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || occupied !== 4'b0000 || free_count !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle: bad cycles=%0d (want 0)", bad);
    end
    do_req(1'b0, 4'd2, 1'b0, 1'b0, 3'd1, 1'b1, lat, ok, room, bill);
    checks++;
    if (lat !== 4 || ok !== 1'b1 || room !== 2'd0 || bill !== 16'd700 ||
        occupied !== 4'b0001 || free_count !== 3'd3) begin
      failures++;
      $display("FAIL post_reset_book: lat=%0d ok=%b room=%0d bill=%0d occ=%b fc=%0d (want 4 1 0 700 0001 3)",
               lat, ok, room, bill, occupied, free_count);
    end
  endtask

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_book_first();
    test_fill();
    test_dup_reject();
    test_checkout();
    test_backpressure();
    test_bill_width();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
